// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encodings and default timing.
package uart_rx_pkg;

  // Receiver FSM encodings; the numeric values are visible on the debug port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

  // 16 MHz / 115200 baud, shared with the transmitter.
  localparam int UART_DIV_DEFAULT = 139;

endpackage

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchroniser for asynchronous input pins.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two register stages; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Handshake: data is offered while valid is high and is consumed on any rising
// clk edge where valid && ready; a byte arriving on that same edge replaces it.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV = UART_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] C_DIV_M1  = CW'(DIV - 1);

  logic            w_rx_s;
  logic            w_tick;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  // Bit-timer event: the counter has run down to zero.
  assign w_tick = (r_cnt == '0);

  // Receive FSM, bit timer, shift register and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // Consume; a delivery on the same edge overrides this below.
      if (r_valid && ready) r_valid <= 1'b0;
      if (!w_tick) r_cnt <= r_cnt - CW'(1);

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= C_HALF_M1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!w_rx_s) begin
              r_cnt   <= C_DIV_M1;
              r_idx   <= '0;
              r_state <= S_DATA;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_cnt   <= C_DIV_M1;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_rx_s) begin
              if (!r_valid || ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so a break yields a single frame_err.
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with DIV=16 (HALF=8).
module tb_uart_rx;

  localparam int DIV = 16;
  // Edges from driving rx low to the stop-sample edge: 2 sync + 1 IDLE + 152.
  localparam int STOP_OFS = 155;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_start = 0;

  // Monitor log
  logic       busy_q = 1'b0;
  logic       valid_q = 1'b0;
  int         busy_rise = -1;
  int         busy_fall = -1;
  int         valid_rise = -1;
  int         fe_cnt = 0;
  int         fe_cyc = -1;
  int         ov_cnt = 0;
  int         ov_cyc = -1;
  int         both_cnt = 0;
  int         valid_hi = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (busy && !busy_q) busy_rise = cyc;
    if (!busy && busy_q) busy_fall = cyc;
    if (valid && !valid_q) begin
      valid_rise = cyc;
      got_q.push_back(data);
    end
    if (valid) valid_hi++;
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (overrun) begin ov_cnt++; ov_cyc = cyc; end
    if (frame_err && overrun) both_cnt++;
    busy_q = busy;
    valid_q = valid;
  end

  task automatic clear_log();
    busy_rise = -1; busy_fall = -1; valid_rise = -1;
    fe_cnt = 0; fe_cyc = -1; ov_cnt = 0; ov_cyc = -1;
    valid_hi = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Driver: called and returns at #1 after a rising edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    tx_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic consume();
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    idle(3);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    idle(4);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_single();
    clear_log();
    ready = 1'b0;
    send_frame(8'hA5, 1'b1);
    idle(2);
    checks++; if (busy_rise - tx_start !== 3) begin failures++; $display("FAIL single_busy_rise got=%0d exp=3", busy_rise - tx_start); end
    checks++; if (busy_fall - tx_start !== STOP_OFS) begin failures++; $display("FAIL single_busy_fall got=%0d exp=%0d", busy_fall - tx_start, STOP_OFS); end
    checks++; if (valid_rise - tx_start !== STOP_OFS) begin failures++; $display("FAIL single_valid_rise got=%0d exp=%0d", valid_rise - tx_start, STOP_OFS); end
    checks++; if (data !== 8'hA5) begin failures++; $display("FAIL single_data got=%0h exp=a5", data); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", valid); end
    checks++; if (fe_cnt + ov_cnt !== 0) begin failures++; $display("FAIL single_err_pulses got=%0d exp=0", fe_cnt + ov_cnt); end
    consume();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL consume_valid got=%0b exp=0", valid); end
    checks++; if (data !== 8'hA5) begin failures++; $display("FAIL consume_data_hold got=%0h exp=a5", data); end
    ready = 1'b1;
    idle(3);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ready_idle_valid got=%0b exp=0", valid); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    ready = 1'b0;
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (valid_hi !== 2) begin failures++; $display("FAIL b2b_valid_cycles got=%0d exp=2", valid_hi); end
    checks++; if (fe_cnt + ov_cnt !== 0) begin failures++; $display("FAIL b2b_err_pulses got=%0d exp=0", fe_cnt + ov_cnt); end
  endtask

  task automatic test_glitch();
    clear_log();
    @(posedge clk); #1;
    tx_start = cyc;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(30);
    checks++; if (busy_rise - tx_start !== 3) begin failures++; $display("FAIL glitch_busy_rise got=%0d exp=3", busy_rise - tx_start); end
    checks++; if (busy_fall - tx_start !== 11) begin failures++; $display("FAIL glitch_busy_fall got=%0d exp=11", busy_fall - tx_start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%0b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%0b exp=0", valid); end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_frame_err();
    int rel;
    clear_log();
    ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    idle(40);
    checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt); end
    checks++; if (fe_cyc - tx_start !== STOP_OFS) begin failures++; $display("FAIL ferr_cycle got=%0d exp=%0d", fe_cyc - tx_start, STOP_OFS); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_busy_held got=%0b exp=1", busy); end
    checks++; if (dbg_state !== 3'd4) begin failures++; $display("FAIL ferr_state got=%0d exp=4", dbg_state); end
    rx = 1'b1;
    rel = cyc;
    idle(6);
    checks++; if (busy_fall - rel !== 3) begin failures++; $display("FAIL ferr_busy_fall got=%0d exp=3", busy_fall - rel); end
    checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL ferr_single got=%0d exp=1", fe_cnt); end
    checks++; if (valid_hi !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", valid_hi); end
    checks++; if (ov_cnt !== 0) begin failures++; $display("FAIL ferr_overrun got=%0d exp=0", ov_cnt); end
  endtask

  task automatic test_overrun();
    clear_log();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2);
    checks++; if (data !== 8'h11) begin failures++; $display("FAIL ovr_data_kept got=%0h exp=11", data); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%0b exp=1", valid); end
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", ov_cnt); end
    checks++; if (ov_cyc - tx_start !== STOP_OFS) begin failures++; $display("FAIL ovr_cycle got=%0d exp=%0d", ov_cyc - tx_start, STOP_OFS); end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL ovr_frame_err got=%0d exp=0", fe_cnt); end
    // Consume and deliver on the same edge
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (STOP_OFS - 1) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        checks++; if (data !== 8'h22) begin failures++; $display("FAIL swap_data got=%0h exp=22", data); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL swap_valid got=%0b exp=1", valid); end
      end
    join
    idle(2);
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL swap_no_overrun got=%0d exp=1", ov_cnt); end
    consume();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL swap_consume got=%0b exp=0", valid); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    ready = 1'b0;
    @(posedge clk); #1;
    drive_bit(1'b0);
    drive_bit(1'b0);   // 0x5A bit0
    drive_bit(1'b1);   // bit1
    drive_bit(1'b0);   // bit2
    checks++; if (dbg_state !== 3'd2) begin failures++; $display("FAIL rstmid_in_data got=%0d exp=2", dbg_state); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%0h exp=0", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", valid); end
    idle(2);
    rx = 1'b1;
    idle(1);
    rst = 1'b0;
    clear_log();
    idle(40);
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rstmid_no_delivery got=%0d exp=0", got_q.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%0b exp=0", busy); end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL rstmid_frame_err got=%0d exp=0", fe_cnt); end
    send_frame(8'h5A, 1'b1);
    idle(2);
    checks++; if (data !== 8'h5A) begin failures++; $display("FAIL rstmid_rx_data got=%0h exp=5a", data); end
    checks++; if (valid_rise - tx_start !== STOP_OFS) begin failures++; $display("FAIL rstmid_rx_latency got=%0d exp=%0d", valid_rise - tx_start, STOP_OFS); end
    consume();
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL err_exclusive got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
